// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_INIT,
    ST_DIV_ITER,
    ST_DIV_FIX
  } state_e;

  // Quotient on divide-by-zero is every bit set to this value.
  localparam logic DIVZ_QUO_FILL = 1'b1;

endpackage

// File: rtl/mips_div_iter.sv
// Restoring radix-2 unsigned divider core, one quotient bit per step.
module mips_div_iter
  import mips_muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W:0]   trial;

  // Shift in the next dividend bit and subtract when it fits.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (!trial[W]) begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[W-2:0], quo_q[W-1]};
        quo_d = {quo_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mips_muldiv.sv
// HI/LO multiply/divide unit. Optional MULDIV_MADD_EN builds the
// MADD/MADDU accumulate path; otherwise ops 6/7 act as MULT/MULTU.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W);

  state_e          state_q, state_d;
  op_e             op_q, op_d, op_in;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]    rs_q, rs_d, rt_q, rt_d;
  logic            done_q, done_d, busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2*W-1:0]  mul_p_q [MUL_STAGES];
  logic [2*W-1:0]  mul_p_d [MUL_STAGES];
  logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
  logic            mul_go, mul_sgn;
  logic [2*W-1:0]  mul_a, mul_b, mul_res;

  logic            div_load, div_step, div_sgn, dvd_neg, dvs_neg;
  logic [W-1:0]    dvd_abs, dvs_abs, div_quo, div_rem;

  assign op_in = op_e'(op);

  // Full-width product: operands are extended to 2W so the low 2W bits are exact.
  always_comb begin
    mul_sgn = (op_in == OP_MULT) || (op_in == OP_MADD);
    mul_a   = mul_sgn ? {{W{rs[W-1]}}, rs} : {{W{1'b0}}, rs};
    mul_b   = mul_sgn ? {{W{rt[W-1]}}, rt} : {{W{1'b0}}, rt};
  end

  always_comb begin
    mul_vld_d[0] = mul_go;
    mul_p_d[0]   = mul_go ? (mul_a * mul_b) : mul_p_q[0];
    for (int unsigned k = 1; k < MUL_STAGES; k++) begin
      mul_vld_d[k] = mul_vld_q[k-1];
      mul_p_d[k]   = mul_p_q[k-1];
    end
  end

`ifdef MULDIV_MADD_EN
  logic [MUL_STAGES-1:0] mul_acc_q, mul_acc_d;

  always_comb begin
    mul_acc_d[0] = (op_in == OP_MADD) || (op_in == OP_MADDU);
    for (int unsigned k = 1; k < MUL_STAGES; k++) begin
      mul_acc_d[k] = mul_acc_q[k-1];
    end
  end

  // Accumulate against HI/LO as they stand on the write edge.
  always_comb begin
    mul_res = mul_acc_q[MUL_STAGES-1] ? ({hi_q, lo_q} + mul_p_q[MUL_STAGES-1])
                                      : mul_p_q[MUL_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mul_acc_q <= '0;
    else        mul_acc_q <= mul_acc_d;
  end
`else
  always_comb mul_res = mul_p_q[MUL_STAGES-1];
`endif

  // Divider sign handling around the unsigned core.
  always_comb begin
    div_sgn = (op_q == OP_DIV);
    dvd_neg = div_sgn & rs_q[W-1];
    dvs_neg = div_sgn & rt_q[W-1];
    dvd_abs = dvd_neg ? -rs_q : rs_q;
    dvs_abs = dvs_neg ? -rt_q : rt_q;
  end

  mips_div_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_go   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_in)
            OP_MTHI: begin
              hi_d   = rs;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op_in;
              rs_d    = rs;
              rt_d    = rt;
              busy_d  = 1'b1;
              state_d = ST_DIV_INIT;
            end
            default: begin
              mul_go  = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_MUL;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_vld_q[MUL_STAGES-1]) begin
          {hi_d, lo_d} = mul_res;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DIV_INIT: begin
        div_load = 1'b1;
        cnt_d    = '0;
        state_d  = ST_DIV_ITER;
      end
      ST_DIV_ITER: begin
        div_step = 1'b1;
        if (cnt_q == CW'(W-1)) state_d = ST_DIV_FIX;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DIV_FIX: begin
        if (rt_q == '0) begin
          lo_d = {W{DIVZ_QUO_FILL}};
          hi_d = rs_q;
        end else begin
          lo_d = (dvd_neg ^ dvs_neg) ? -div_quo : div_quo;
          hi_d = dvd_neg ? -div_rem : div_rem;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mul_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mul_vld_q <= mul_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < MUL_STAGES; k++) begin
      mul_p_q[k] <= mul_p_d[k];
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Randomised bench for mips_muldiv against an arithmetic reference model.
module tb_mips_muldiv;

  localparam int W  = 32;
  localparam int MS = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mips_muldiv #(.W(W), .MUL_STAGES(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, plus cycles from accept to done.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] ohi, input logic [W-1:0] olo,
                                 output logic [W-1:0] nhi, output logic [W-1:0] nlo, output int lat);
    longint      sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    nhi = ohi;
    nlo = olo;
    lat = 0;
    p   = '0;
    case (o)
      3'd2, 3'd3: begin
        lat = W + 2;
        if (b == 0) begin
          nlo = '1;
          nhi = a;
        end else if (o == 3'd2) begin
          nlo = 32'(sa / sb);
          nhi = 32'(sa % sb);
        end else begin
          nlo = a / b;
          nhi = a % b;
        end
      end
      3'd4: nhi = a;
      3'd5: nlo = a;
      default: begin
        lat = MS;
        if (o == 3'd0 || o == 3'd6) p = 64'(sa * sb);
        else                        p = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_MADD_EN
        if (o >= 3'd6) p = p + {ohi, olo};
`endif
        {nhi, nlo} = p;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] ehi, elo;
    int lat, n;
    ref_op(o, a, b, m_hi, m_lo, ehi, elo, lat);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs = $urandom; rt = $urandom;
    if (lat > 0) chk({tag, " busy"}, busy, 1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " busy@done"}, busy, 0);
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " hi hold"}, hi, m_hi);
    chk({tag, " lo hold"}, lo, m_lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ehi, elo, dhi, dlo;
    int lat, n, ndone, first;

    rst_n = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, "mult");
    chk("tp mult hi", hi, 32'hFFFF_FFFF);
    chk("tp mult lo", lo, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu");
    chk("tp multu hi", hi, 32'h0000_0001);
    chk("tp multu lo", lo, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    chk("tp div lo", lo, 32'hFFFF_FFFD);
    chk("tp div hi", hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd2, "divu");
    chk("tp divu lo", lo, 32'd3);
    chk("tp divu hi", hi, 32'd1);
    run_op(3'd3, 32'd7, 32'd0, "divu0");
    chk("tp divu0 lo", lo, 32'hFFFF_FFFF);
    chk("tp divu0 hi", hi, 32'd7);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    chk("tp divovf lo", lo, 32'h8000_0000);
    chk("tp divovf hi", hi, 32'd0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, "div0");
    idle_cycle("post div");

    run_op(3'd5, 32'h0000_1234, 32'd0, "mtlo");
    chk("tp mtlo lo", lo, 32'h0000_1234);
    chk("tp mtlo hi", hi, 32'hFFFF_FFF9);
    idle_cycle("post mtlo");
    run_op(3'd4, 32'hCAFE_0001, 32'd0, "b2b mthi");
    run_op(3'd5, 32'hBEEF_0002, 32'd0, "b2b mtlo");
    idle_cycle("post b2b");

    // Starts presented while a divide is in flight must be dropped.
    ref_op(3'd2, 32'hFFFF_FF9C, 32'd7, m_hi, m_lo, ehi, elo, lat);
    start = 1'b1; op = 3'd2; rs = 32'hFFFF_FF9C; rt = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0;
    n = 0; ndone = 0; first = -1; dhi = '0; dlo = '0;
    while (n < 45) begin
      if (done) begin
        if (ndone == 0) begin
          first = n; dhi = hi; dlo = lo;
        end
        ndone++;
      end
      if (n == 10) chk("ign busy", busy, 1);
      if (n == 33) start = 1'b0;
      rs = $urandom; rt = $urandom;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("ign done count", ndone, 1);
    chk("ign latency", first, lat);
    chk("ign hi", dhi, ehi);
    chk("ign lo", dlo, elo);
    m_hi = ehi; m_lo = elo;

    // Reset in the middle of the divide iterations.
    start = 1'b1; op = 3'd3; rs = $urandom; rt = $urandom | 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst no done", ndone, 0);
    run_op(3'd3, 32'd100, 32'd7, "divu after rst");
    chk("tp 100/7 lo", lo, 32'd14);
    chk("tp 100/7 hi", hi, 32'd2);

    run_op(3'd4, 32'd0, 32'd0, "madd mthi");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, "madd mtlo");
    run_op(3'd7, 32'd1, 32'd1, "maddu");
`ifdef MULDIV_MADD_EN
    chk("tp maddu hi", hi, 32'd1);
    chk("tp maddu lo", lo, 32'd0);
`else
    chk("tp maddu hi", hi, 32'd0);
    chk("tp maddu lo", lo, 32'd1);
`endif
    idle_cycle("post madd");

    for (int i = 0; i < 80; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand");
      if ($urandom_range(0, 3) == 0) idle_cycle("rand idle");
    end
    idle_cycle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
